// File: rtl/reg_wb_queue.sv
// Write-back queue for the 32x32 register file: merges MEM and ALU results in order,
// drains one entry per cycle to the write port and exposes a read bypass.
module reg_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       mem_valid,
  input  logic [AW-1:0]              mem_addr,
  input  logic [DW-1:0]              mem_data,
  output logic                       mem_ready,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_addr,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  output logic                       Write_Reg,
  output logic [AW-1:0]              W_Addr,
  output logic [DW-1:0]              W_Data,
  input  logic [AW-1:0]              R_Addr_A,
  input  logic [AW-1:0]              R_Addr_B,
  output logic                       hit_a,
  output logic [DW-1:0]              byp_a,
  output logic                       hit_b,
  output logic [DW-1:0]              byp_b,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_count;

  logic             w_mem_acc;
  logic             w_alu_acc;
  logic             w_mem_st;
  logic             w_alu_st;
  logic             w_pop;
  logic [PW-1:0]    w_alu_slot;
  logic [PW-1:0]    w_age_idx [DEPTH];

  // Credit is taken from the count at the start of the cycle; a pop gives none back.
  assign mem_ready  = (r_count != CW'(DEPTH));
  assign alu_ready  = (r_count <= CW'(DEPTH - 2)) | (mem_ready & ~mem_valid);

  assign w_mem_acc  = mem_valid & mem_ready;
  assign w_alu_acc  = alu_valid & alu_ready;
  assign w_mem_st   = w_mem_acc & (mem_addr != '0);
  assign w_alu_st   = w_alu_acc & (alu_addr != '0);
  assign w_pop      = (r_count != '0);
  assign w_alu_slot = r_wr + PW'(w_mem_st);

  assign Write_Reg  = w_pop;
  assign W_Addr     = w_pop ? r_addr[r_rd] : '0;
  assign W_Data     = w_pop ? r_data[r_rd] : '0;
  assign count      = r_count;

  // Slot index of the i-th oldest entry, so the bypass scan runs oldest to youngest.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign w_age_idx[g] = r_rd + PW'(g);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_valid[r_rd] <= 1'b0;
        r_rd          <= r_rd + PW'(1);
      end
      if (w_mem_st) begin
        r_addr[r_wr]  <= mem_addr;
        r_data[r_wr]  <= mem_data;
        r_valid[r_wr] <= 1'b1;
      end
      if (w_alu_st) begin
        r_addr[w_alu_slot]  <= alu_addr;
        r_data[w_alu_slot]  <= alu_data;
        r_valid[w_alu_slot] <= 1'b1;
      end
      r_wr    <= r_wr + PW'(w_mem_st) + PW'(w_alu_st);
      r_count <= r_count + CW'(w_mem_st) + CW'(w_alu_st) - CW'(w_pop);
    end
  end

  // Later (younger) matches overwrite earlier ones; R0 never hits.
  always_comb begin
    hit_a = 1'b0;
    byp_a = '0;
    hit_b = 1'b0;
    byp_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[w_age_idx[i]] && (r_addr[w_age_idx[i]] == R_Addr_A) && (R_Addr_A != '0)) begin
        hit_a = 1'b1;
        byp_a = r_data[w_age_idx[i]];
      end
      if (r_valid[w_age_idx[i]] && (r_addr[w_age_idx[i]] == R_Addr_B) && (R_Addr_B != '0)) begin
        hit_b = 1'b1;
        byp_b = r_data[w_age_idx[i]];
      end
    end
  end

endmodule

// File: tb/tb_reg_wb_queue.sv
// Bench for reg_wb_queue: directed vector table, async reset sequence and a
// randomized stream checked against a queue model.
module tb_reg_wb_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_addr, alu_addr;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        Write_Reg;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic [4:0]  R_Addr_A, R_Addr_B;
  logic        hit_a, hit_b;
  logic [31:0] byp_a, byp_b;
  logic [2:0]  count;

  reg_wb_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B),
    .hit_a(hit_a), .byp_a(byp_a), .hit_b(hit_b), .byp_b(byp_b),
    .count(count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic        av;  logic [4:0] aa; logic [31:0] ad;
    logic [4:0]  ra;  logic [4:0] rb;
    logic        e_mr; logic e_ar; logic e_wr;
    logic [4:0]  e_wa; logic [31:0] e_wd;
    logic        e_ha; logic [31:0] e_ba;
    logic        e_hb; logic [31:0] e_bb;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  int n_pass  = 0;
  int n_total = 0;

  logic [36:0] q [$];
  logic [31:0] model_rf [32];
  logic [31:0] dut_rf   [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(
    input logic mv, input logic [4:0] ma, input logic [31:0] md,
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic [4:0] ra, input logic [4:0] rb,
    input logic e_mr, input logic e_ar, input logic e_wr,
    input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic e_ha, input logic [31:0] e_ba,
    input logic e_hb, input logic [31:0] e_bb, input logic [2:0] e_cnt);
    vec_t v;
    v.mv = mv; v.ma = ma; v.md = md; v.av = av; v.aa = aa; v.ad = ad;
    v.ra = ra; v.rb = rb; v.e_mr = e_mr; v.e_ar = e_ar; v.e_wr = e_wr;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_ha = e_ha; v.e_ba = e_ba;
    v.e_hb = e_hb; v.e_bb = e_bb; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic drive_idle();
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
  endtask

  // Compare DUT against the queue model for the current cycle, then advance the model.
  task automatic model_step(input string tag);
    int          free;
    logic        e_mr, e_ar, e_ha, e_hb;
    logic [31:0] e_ba, e_bb;
    logic [36:0] head;
    free = 4 - q.size();
    e_mr = (free >= 1);
    e_ar = (free >= 2) || ((free >= 1) && !mem_valid);
    head = (q.size() != 0) ? q[0] : 37'd0;
    e_ha = 1'b0; e_ba = '0; e_hb = 1'b0; e_bb = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i][36:32] == R_Addr_A && R_Addr_A != 5'd0) begin e_ha = 1'b1; e_ba = q[i][31:0]; end
      if (q[i][36:32] == R_Addr_B && R_Addr_B != 5'd0) begin e_hb = 1'b1; e_bb = q[i][31:0]; end
    end
    chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(e_mr));
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(e_ar));
    chk({tag, ".Write_Reg"}, 32'(Write_Reg), 32'(q.size() != 0));
    chk({tag, ".W_Addr"},    32'(W_Addr),    32'(head[36:32]));
    chk({tag, ".W_Data"},    W_Data,         head[31:0]);
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".hit_a"},     32'(hit_a),     32'(e_ha));
    chk({tag, ".byp_a"},     byp_a,          e_ba);
    chk({tag, ".hit_b"},     32'(hit_b),     32'(e_hb));
    chk({tag, ".byp_b"},     byp_b,          e_bb);
    if (Write_Reg) dut_rf[W_Addr] = W_Data;
    if (q.size() != 0) begin
      model_rf[head[36:32]] = head[31:0];
      void'(q.pop_front());
    end
    if (mem_valid && e_mr && mem_addr != 5'd0) q.push_back({mem_addr, mem_data});
    if (alu_valid && e_ar && alu_addr != 5'd0) q.push_back({alu_addr, alu_data});
  endtask

  initial begin
    tbl[0]  = mk(0,0,0,             0,0,0,             0,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[1]  = mk(1,5,32'hAAAA0001,  0,0,0,             5,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[2]  = mk(0,0,0,             0,0,0,             5,0,  1,1,1,5,32'hAAAA0001,  1,32'hAAAA0001,0,0,1);
    tbl[3]  = mk(0,0,0,             0,0,0,             5,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[4]  = mk(1,3,32'h11,        1,3,32'h22,        3,3,  1,1,0,0,0,             0,0,0,0,0);
    tbl[5]  = mk(0,0,0,             0,0,0,             3,3,  1,1,1,3,32'h11,        1,32'h22,1,32'h22,2);
    tbl[6]  = mk(0,0,0,             0,0,0,             3,0,  1,1,1,3,32'h22,        1,32'h22,0,0,1);
    tbl[7]  = mk(0,0,0,             0,0,0,             3,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[8]  = mk(0,0,0,             1,0,32'hDEAD,      0,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[9]  = mk(0,0,0,             0,0,0,             0,0,  1,1,0,0,0,             0,0,0,0,0);
    tbl[10] = mk(1,1,32'hA1,        1,2,32'hA2,        1,2,  1,1,0,0,0,             0,0,0,0,0);
    tbl[11] = mk(1,4,32'hB1,        1,6,32'hB2,        1,2,  1,1,1,1,32'hA1,        1,32'hA1,1,32'hA2,2);
    tbl[12] = mk(1,7,32'hC1,        1,8,32'hC2,        2,8,  1,0,1,2,32'hA2,        1,32'hA2,0,0,3);
    tbl[13] = mk(0,0,0,             1,9,32'hD1,        6,7,  1,1,1,4,32'hB1,        1,32'hB2,1,32'hC1,3);
    tbl[14] = mk(1,0,0,             1,10,32'hE,        9,10, 1,0,1,6,32'hB2,        1,32'hD1,0,0,3);
    tbl[15] = mk(0,0,0,             0,0,0,             7,9,  1,1,1,7,32'hC1,        1,32'hC1,1,32'hD1,2);
    tbl[16] = mk(0,0,0,             0,0,0,             10,0, 1,1,1,9,32'hD1,        0,0,0,0,1);
    tbl[17] = mk(0,0,0,             0,0,0,             0,0,  1,1,0,0,0,             0,0,0,0,0);

    for (int i = 0; i < 32; i++) begin model_rf[i] = '0; dut_rf[i] = '0; end

    RST = 1'b1;
    drive_idle();
    R_Addr_A = '0; R_Addr_B = '0;
    #2;
    chk("reset.Write_Reg", 32'(Write_Reg), 32'd0);
    chk("reset.W_Addr",    32'(W_Addr),    32'd0);
    chk("reset.W_Data",    W_Data,         32'd0);
    chk("reset.count",     32'(count),     32'd0);
    chk("reset.mem_ready", 32'(mem_ready), 32'd1);
    chk("reset.alu_ready", 32'(alu_ready), 32'd1);
    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      mem_valid = tbl[i].mv; mem_addr = tbl[i].ma; mem_data = tbl[i].md;
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      R_Addr_A  = tbl[i].ra; R_Addr_B = tbl[i].rb;
      #2;
      chk($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
      chk($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      chk($sformatf("vec%0d.Write_Reg", i), 32'(Write_Reg), 32'(tbl[i].e_wr));
      chk($sformatf("vec%0d.W_Addr", i),    32'(W_Addr),    32'(tbl[i].e_wa));
      chk($sformatf("vec%0d.W_Data", i),    W_Data,         tbl[i].e_wd);
      chk($sformatf("vec%0d.hit_a", i),     32'(hit_a),     32'(tbl[i].e_ha));
      chk($sformatf("vec%0d.byp_a", i),     byp_a,          tbl[i].e_ba);
      chk($sformatf("vec%0d.hit_b", i),     32'(hit_b),     32'(tbl[i].e_hb));
      chk($sformatf("vec%0d.byp_b", i),     byp_b,          tbl[i].e_bb);
      chk($sformatf("vec%0d.count", i),     32'(count),     32'(tbl[i].e_cnt));
    end

    // Async reset with three entries queued: everything clears without a clock edge.
    @(negedge CLK);
    mem_valid = 1'b1; mem_addr = 5'd1; mem_data = 32'h101;
    alu_valid = 1'b1; alu_addr = 5'd2; alu_data = 32'h102;
    @(negedge CLK);
    mem_addr = 5'd3; mem_data = 32'h103;
    alu_addr = 5'd4; alu_data = 32'h104;
    @(negedge CLK);
    drive_idle();
    R_Addr_A = 5'd4;
    #1;
    chk("rstmid.pre_count", 32'(count), 32'd3);
    chk("rstmid.pre_hit_a", 32'(hit_a), 32'd1);
    #1;
    RST = 1'b1;
    #1;
    chk("rstmid.Write_Reg", 32'(Write_Reg), 32'd0);
    chk("rstmid.count",     32'(count),     32'd0);
    chk("rstmid.hit_a",     32'(hit_a),     32'd0);
    chk("rstmid.W_Data",    W_Data,         32'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      #2;
      chk($sformatf("rstpost%0d.Write_Reg", i), 32'(Write_Reg), 32'd0);
      chk($sformatf("rstpost%0d.count", i),     32'(count),     32'd0);
    end

    // Random stream against the queue model, then drain.
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      mem_valid = 1'($urandom_range(0, 1));
      mem_addr  = 5'($urandom_range(0, 7));
      mem_data  = $urandom;
      alu_valid = 1'($urandom_range(0, 1));
      alu_addr  = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      R_Addr_A  = 5'($urandom_range(0, 7));
      R_Addr_B  = 5'($urandom_range(0, 7));
      #2;
      model_step($sformatf("rnd%0d", c));
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      drive_idle();
      #2;
      model_step($sformatf("drain%0d", c));
    end
    for (int i = 0; i < 32; i++)
      chk($sformatf("regfile[%0d]", i), dut_rf[i], model_rf[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
